// File: rtl/fb_fetch_arbiter.sv
// Frame-buffer SRAM arbiter: display prefetch FIFO plus host writes into spare slots.
module fb_fetch_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LOW_WM   = 4,
    parameter int unsigned FB_WORDS = 19200
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          frame_start,
    input  logic          pix_pop,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          underflow,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = PW + 2;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_flush_cnt;
    logic          w_flush_cnt_nxt;

    logic [DW-1:0] r_fifo [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_fetch_addr;
    logic          r_rd_p2;
    logic          r_underflow;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_we;
    logic          r_mem_re;

    logic [LW-1:0] w_level;
    logic          w_active;
    logic          w_clear;
    logic          w_grant_rd;
    logic          w_grant_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_uf_set;

    // State register for the run/flush sequencer
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next state: frame_start (re)starts a two-cycle flush
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_RUN: begin
                if (frame_start) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (frame_start) begin
                    w_flush_cnt_nxt = 1'b0;
                end else if (r_flush_cnt) begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = 1'b0;
                end else begin
                    w_flush_cnt_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_flush_cnt_nxt = 1'b0;
            end
        endcase
    end

    // Slot grant: refill below watermark, else host, else top up the FIFO
    always_comb begin
        w_level    = LW'(r_count) + LW'(r_mem_re) + LW'(r_rd_p2);
        w_active   = (r_state == ST_RUN) && !frame_start;
        w_clear    = frame_start || (r_state == ST_FLUSH);
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        if (w_active) begin
            if (w_level < LW'(LOW_WM)) begin
                w_grant_rd = 1'b1;
            end else if (host_valid) begin
                w_grant_wr = 1'b1;
            end else if (w_level < LW'(DEPTH)) begin
                w_grant_rd = 1'b1;
            end
        end
        // Data for reads issued before a frame_start lands during the flush and is dropped
        w_push   = r_rd_p2 && w_active;
        w_pop    = pix_pop && (r_count != CW'(0)) && w_active;
        w_uf_set = pix_pop && (r_count == CW'(0)) && w_active;
    end

    // Prefetch FIFO storage and occupancy
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_rdata;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // SRAM command register, fetch pointer, read-return tracking, sticky underflow
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_rd_p2      <= 1'b0;
            r_fetch_addr <= '0;
            r_underflow  <= 1'b0;
        end else begin
            r_mem_re <= w_grant_rd;
            r_mem_we <= w_grant_wr;
            r_rd_p2  <= r_mem_re;
            if (w_grant_rd) begin
                r_mem_addr <= r_fetch_addr;
            end else if (w_grant_wr) begin
                r_mem_addr  <= host_addr;
                r_mem_wdata <= host_data;
            end
            if (w_clear) begin
                r_fetch_addr <= '0;
            end else if (w_grant_rd) begin
                r_fetch_addr <= (r_fetch_addr == AW'(FB_WORDS - 1)) ? '0 : r_fetch_addr + AW'(1);
            end
            if (w_clear) begin
                r_underflow <= 1'b0;
            end else if (w_uf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign pix_data   = r_fifo[r_rd_ptr];
    assign pix_valid  = (r_count != CW'(0));
    assign underflow  = r_underflow;
    assign host_ready = w_grant_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign mem_re     = r_mem_re;

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Directed bench for fb_fetch_arbiter with a registered-read SRAM model.
module tb_fb_fetch_arbiter;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_pop = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        underflow;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [15:0] host_addr = '0;
    logic [7:0]  host_data = '0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  sram [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        fs;
        logic        pop;
        logic        hv;
        logic [15:0] haddr;
        logic [7:0]  hdata;
        logic        e_re;
        logic        e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_hr;
        logic        e_uf;
    } vec_t;

    vec_t tbl [0:30];

    fb_fetch_arbiter #(
        .AW(16), .DW(8), .DEPTH(8), .LOW_WM(4), .FB_WORDS(20)
    ) dut (
        .clk(clk), .RESET(RESET), .frame_start(frame_start), .pix_pop(pix_pop),
        .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM: write on mem_we, read data valid the cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    function automatic int word(input int a);
        return (a * 17 + 5) % 256;
    endfunction

    function automatic vec_t mk(input int fs, input int pop, input int hv, input int ha,
                                input int hd, input int re, input int we, input int ad,
                                input int wd, input int v, input int d, input int hr,
                                input int uf);
        vec_t r;
        r.fs = 1'(fs);      r.pop = 1'(pop);     r.hv = 1'(hv);
        r.haddr = 16'(ha);  r.hdata = 8'(hd);
        r.e_re = 1'(re);    r.e_we = 1'(we);     r.e_addr = 16'(ad);
        r.e_wdata = 8'(wd); r.e_valid = 1'(v);   r.e_data = 8'(d);
        r.e_hr = 1'(hr);    r.e_uf = 1'(uf);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int  exp_addr;
        int  k;
        int  nreads;
        bit  got;

        for (int i = 0; i < 65536; i++) sram[i] = 8'(word(i));

        // Vectors: T1 fill (with an early pop on empty), T2/T3 host traffic, T4 frame_start
        tbl[0]  = mk(0,0,0,0,0,        0,0,0,0,            0,0,        0,0);
        tbl[1]  = mk(0,1,0,0,0,        1,0,0,0,            0,0,        0,0);
        tbl[2]  = mk(0,0,0,0,0,        1,0,1,0,            0,0,        0,1);
        for (int i = 3; i <= 8; i++)
            tbl[i] = mk(0,0,0,0,0,     1,0,i-1,0,          1,word(0),  0,1);
        tbl[9]  = mk(0,0,0,0,0,        0,0,0,0,            1,word(0),  0,1);
        tbl[10] = mk(0,0,0,0,0,        0,0,0,0,            1,word(0),  0,1);
        tbl[11] = mk(0,0,1,'h0123,'hA5, 0,0,0,0,           1,word(0),  1,1);
        tbl[12] = mk(0,0,0,0,0,        0,1,'h0123,'hA5,    1,word(0),  0,1);
        tbl[13] = mk(0,1,1,'h0200,'h3C, 0,0,0,0,           1,word(0),  1,1);
        for (int i = 14; i <= 17; i++)
            tbl[i] = mk(0,1,1,'h0200,'h3C, 0,1,'h0200,'h3C, 1,word(i-13), 1,1);
        tbl[18] = mk(0,0,1,'h0200,'h3C, 0,1,'h0200,'h3C,   1,word(5),  0,1);
        tbl[19] = mk(0,0,1,'h0200,'h3C, 1,0,8,0,           1,word(5),  1,1);
        tbl[20] = mk(0,0,1,'h0200,'h3C, 0,1,'h0200,'h3C,   1,word(5),  1,1);
        tbl[21] = mk(0,0,1,'h0200,'h3C, 0,1,'h0200,'h3C,   1,word(5),  1,1);
        tbl[22] = mk(0,0,0,0,0,        0,1,'h0200,'h3C,    1,word(5),  0,1);
        tbl[23] = mk(0,0,0,0,0,        1,0,9,0,            1,word(5),  0,1);
        tbl[24] = mk(1,0,0,0,0,        1,0,10,0,           1,word(5),  0,1);
        tbl[25] = mk(0,1,1,'h0300,'h11, 0,0,0,0,           0,0,        0,0);
        tbl[26] = mk(0,1,1,'h0300,'h11, 0,0,0,0,           0,0,        0,0);
        tbl[27] = mk(0,1,0,0,0,        0,0,0,0,            0,0,        0,0);
        tbl[28] = mk(0,0,0,0,0,        1,0,0,0,            0,0,        0,1);
        tbl[29] = mk(0,0,0,0,0,        1,0,1,0,            0,0,        0,1);
        tbl[30] = mk(0,0,0,0,0,        1,0,2,0,            1,word(0),  0,1);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_re",    32'(mem_re),    32'(0));
        chk("rst_mem_we",    32'(mem_we),    32'(0));
        chk("rst_mem_addr",  32'(mem_addr),  32'(0));
        chk("rst_pix_valid", 32'(pix_valid), 32'(0));
        chk("rst_underflow", 32'(underflow), 32'(0));

        @(negedge clk);
        RESET = 1'b1;
        for (int i = 0; i < 31; i++) begin
            if (i > 0) @(negedge clk);
            frame_start = tbl[i].fs;
            pix_pop     = tbl[i].pop;
            host_valid  = tbl[i].hv;
            host_addr   = tbl[i].haddr;
            host_data   = tbl[i].hdata;
            #1;
            chk($sformatf("v%0d_mem_re", i),     32'(mem_re),     32'(tbl[i].e_re));
            chk($sformatf("v%0d_mem_we", i),     32'(mem_we),     32'(tbl[i].e_we));
            chk($sformatf("v%0d_host_ready", i), 32'(host_ready), 32'(tbl[i].e_hr));
            chk($sformatf("v%0d_pix_valid", i),  32'(pix_valid),  32'(tbl[i].e_valid));
            chk($sformatf("v%0d_underflow", i),  32'(underflow),  32'(tbl[i].e_uf));
            if (tbl[i].e_re || tbl[i].e_we)
                chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_we)
                chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wdata));
            if (tbl[i].e_valid)
                chk($sformatf("v%0d_pix_data", i), 32'(pix_data), 32'(tbl[i].e_data));
        end

        // Free-running pops: read addresses wrap 19 -> 0, popped words follow the frame
        exp_addr = 3;
        k        = 0;
        nreads   = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            pix_pop     = 1'b1;
            host_valid  = 1'b0;
            #1;
            chk("t6_no_write", 32'(mem_we), 32'(0));
            if (mem_re) begin
                chk($sformatf("t6_addr%0d", nreads), 32'(mem_addr), 32'(exp_addr));
                exp_addr = (exp_addr + 1) % 20;
                nreads++;
            end
            if (pix_valid) begin
                chk($sformatf("t6_data%0d", k), 32'(pix_data), 32'(word(k % 20)));
                k++;
            end
        end
        chk("t6_enough_reads", 32'(nreads >= 25), 32'(1));

        // Host write, then asynchronous reset in the middle of the write cycle
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            pix_pop    = 1'b0;
            host_valid = 1'b1;
            host_addr  = 16'h0055;
            host_data  = 8'h66;
            #1;
            if (host_ready) got = 1'b1;
        end
        chk("t6_host_served", 32'(got), 32'(1));
        if (got) begin
            @(posedge clk);
            #2;
            chk("t6_we_before_rst",    32'(mem_we),    32'(1));
            chk("t6_addr_before_rst",  32'(mem_addr),  32'h55);
            chk("t6_wdata_before_rst", 32'(mem_wdata), 32'h66);
            RESET = 1'b0;
            #1;
            chk("t6_we_async_rst",    32'(mem_we),    32'(0));
            chk("t6_re_async_rst",    32'(mem_re),    32'(0));
            chk("t6_addr_async_rst",  32'(mem_addr),  32'(0));
            chk("t6_valid_async_rst", 32'(pix_valid), 32'(0));
            chk("t6_uf_async_rst",    32'(underflow), 32'(0));
        end
        host_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
